row_track: RTL and testbench
============================

ROW_TRACK -- requirements
Module: row_track

Interface
REQ-001 Parameter ROWW, default 11: row address width in bits.
REQ-002 Parameter BANKB, default 2: bank select width; NB = 2**BANKB banks tracked.
REQ-003 Parameter IDLE_MAX, default 255: idle cycles before auto-close; range 1..65535.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 resl  input  1  reset, asynchronous, active-low.
REQ-006 a  input  ROWW  row address of current request.
REQ-007 bank  input  BANKB  bank select of current request.
REQ-008 newrow  input  1  strobe: row a opened in bank `bank` this cycle.
REQ-009 access  input  1  strobe: column access to bank `bank`; restarts its idle timer.
REQ-010 close  input  1  strobe: bank `bank` precharged by controller.
REQ-011 closeall  input  1  strobe: all banks precharged (refresh).
REQ-012 match  output  1  combinational page hit for (bank, a).
REQ-013 openmask  output  NB  registered; bit n = bank n holds an open row.
REQ-014 preq  output  1  registered auto-precharge request.
REQ-015 pbank  output  BANKB  bank for preq; stable while preq high.
REQ-016 pack  input  1  precharge acknowledge for pbank.

Function
REQ-017 Per bank: row register ra[n] (ROWW bits), state CLOSED/OPEN/PEND, idle counter ctr[n] (16 bits).
REQ-018 match = (state[bank] is OPEN or PEND) and ra[bank] == a; no clock latency.
REQ-019 newrow: ra[bank] <= a, state[bank] <= OPEN, ctr[bank] <= 0; match true from next cycle.
REQ-020 access with match true: ctr[bank] <= 0; access without match has no effect.
REQ-021 OPEN bank not addressed by newrow/access: ctr increments by 1 per cycle, saturating at IDLE_MAX.
REQ-022 OPEN bank with ctr == IDLE_MAX: state <= PEND.
REQ-023 Arbiter: when preq low, lowest-numbered PEND bank loaded into pbank, preq <= 1 next cycle.
REQ-024 preq stays high, pbank stable, until pack sampled high; then preq <= 0, state[pbank] <= CLOSED.
REQ-025 After pack, preq low for at least one cycle before the next request.
REQ-026 close: state[bank] <= CLOSED; if bank == pbank with preq high, preq <= 0 next cycle.
REQ-027 closeall: all states <= CLOSED, all ctr <= 0, preq <= 0.
REQ-028 Priority on conflicts: closeall > newrow > close > pack > timer; newrow to pbank with preq high drops preq, bank OPEN with new row.
REQ-029 pack with preq low: ignored.
REQ-030 openmask bit n = 1 when state[n] is OPEN or PEND.
REQ-031 ra[n] retains value when CLOSED; match still false.

Reset
REQ-032 resl low: all states CLOSED, ra = 0, ctr = 0, openmask = 0, preq = 0, pbank = 0, immediately, without clk.
REQ-033 Reset mid-handshake: preq drops asynchronously; pending request lost; no pack required.
REQ-034 First newrow honoured on the first rising edge after resl deasserts.

Configuration
REQ-035 Macro ROW_TRACK_TIMEOUT_EN defined: idle counters, PEND state, preq/pbank/pack behave as REQ-021..REQ-029.
REQ-036 Macro undefined: no counters or PEND state; banks stay OPEN until close/closeall/newrow; preq = 0, pbank = 0, pack ignored.

Verification
REQ-037 Reset, newrow bank 1 a=0x2A5 -> next cycle match=1 for (1,0x2A5), 0 for (1,0x2A4) and (0,0x2A5); openmask=0010.
REQ-038 Open banks 0 and 3, closeall pulse -> next cycle openmask=0000, match=0 for both stored rows.
REQ-039 TIMEOUT_EN, IDLE_MAX=4, newrow bank 2, no access -> bank PEND after 4 cycles, preq=1 pbank=2 following cycle; pack -> preq=0, openmask bit 2 clear.
REQ-040 TIMEOUT_EN, IDLE_MAX=4, access with match every 3 cycles for 20 cycles -> preq never asserted.
REQ-041 Banks 1 and 3 PEND simultaneously -> pbank=1 first; after pack, one idle cycle, then pbank=3.
REQ-042 preq high pbank=0, newrow bank 0 a=0x100 same cycle as pack -> preq=0, bank 0 OPEN, match for 0x100; resl low mid-request -> preq=0 at once.

Source files
------------

// File: rtl/row_track.sv
// row_track: per-bank open-row tracker with combinational page-hit compare.
// Define ROW_TRACK_TIMEOUT_EN to add idle auto-precharge requests.
module row_track #(
  parameter int ROWW     = 11,
  parameter int BANKB    = 2,
  parameter int IDLE_MAX = 255
) (
  input  logic                  clk,
  input  logic                  resl,
  input  logic [ROWW-1:0]       a,
  input  logic [BANKB-1:0]      bank,
  input  logic                  newrow,
  input  logic                  access,
  input  logic                  close,
  input  logic                  closeall,
  output logic                  match,
  output logic [(1<<BANKB)-1:0] openmask,
  output logic                  preq,
  output logic [BANKB-1:0]      pbank,
  input  logic                  pack
);

  localparam int NB = 1 << BANKB;
  localparam logic [15:0] IMAX = 16'(IDLE_MAX);

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_OPEN,
    ST_PEND
  } st_e;

  st_e             st_q [NB];
  st_e             st_d [NB];
  logic [ROWW-1:0] ra_q [NB];
  logic [ROWW-1:0] ra_d [NB];
  logic [NB-1:0]   sel;
  logic            hit;

  always_comb begin
    for (int n = 0; n < NB; n++) begin
      sel[n]      = (bank == BANKB'(n));
      openmask[n] = (st_q[n] != ST_CLOSED);
    end
  end

  assign hit   = (st_q[bank] != ST_CLOSED) && (ra_q[bank] == a);
  assign match = hit;

`ifdef ROW_TRACK_TIMEOUT_EN
  logic [15:0]      ctr_q [NB];
  logic [15:0]      ctr_d [NB];
  logic             preq_q, preq_d;
  logic [BANKB-1:0] pbank_q, pbank_d;
  logic [NB-1:0]    ack;
  logic [NB-1:0]    touch;

  always_comb begin
    for (int n = 0; n < NB; n++) begin
      ack[n]   = preq_q && pack && (pbank_q == BANKB'(n));
      touch[n] = sel[n] && (newrow || (access && hit));
    end
  end
`endif

  always_comb begin
    for (int n = 0; n < NB; n++) begin
      st_d[n] = st_q[n];
      ra_d[n] = ra_q[n];
      if (closeall) begin
        st_d[n] = ST_CLOSED;
      end else if (newrow && sel[n]) begin
        ra_d[n] = a;
        st_d[n] = ST_OPEN;
      end else if (close && sel[n]) begin
        st_d[n] = ST_CLOSED;
`ifdef ROW_TRACK_TIMEOUT_EN
      end else if (ack[n]) begin
        st_d[n] = ST_CLOSED;
      end else if (st_q[n] == ST_OPEN && !touch[n] &&
                   ctr_q[n] == IMAX) begin
        st_d[n] = ST_PEND;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      for (int n = 0; n < NB; n++) begin
        st_q[n] <= ST_CLOSED;
        ra_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NB; n++) begin
        st_q[n] <= st_d[n];
        ra_q[n] <= ra_d[n];
      end
    end
  end

`ifdef ROW_TRACK_TIMEOUT_EN
  always_comb begin
    for (int n = 0; n < NB; n++) begin
      ctr_d[n] = ctr_q[n];
      if (closeall || touch[n]) begin
        ctr_d[n] = '0;
      end else if (st_q[n] == ST_OPEN && ctr_q[n] < IMAX) begin
        ctr_d[n] = ctr_q[n] + 16'd1;
      end
    end
  end

  // Arbiter only loads while idle, so the cycle after an ack is always low.
  always_comb begin
    preq_d  = preq_q;
    pbank_d = pbank_q;
    if (closeall) begin
      preq_d = 1'b0;
    end else if (preq_q) begin
      if (pack || ((newrow || close) && bank == pbank_q)) begin
        preq_d = 1'b0;
      end
    end else begin
      for (int n = NB - 1; n >= 0; n--) begin
        if (st_q[n] == ST_PEND && !((newrow || close) && sel[n])) begin
          preq_d  = 1'b1;
          pbank_d = BANKB'(n);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      for (int n = 0; n < NB; n++) begin
        ctr_q[n] <= '0;
      end
      preq_q  <= 1'b0;
      pbank_q <= '0;
    end else begin
      for (int n = 0; n < NB; n++) begin
        ctr_q[n] <= ctr_d[n];
      end
      preq_q  <= preq_d;
      pbank_q <= pbank_d;
    end
  end

  assign preq  = preq_q;
  assign pbank = pbank_q;
`else
  logic [17:0] unused_cfg;

  assign unused_cfg = {pack, access, IMAX};
  assign preq       = 1'b0;
  assign pbank      = '0;
`endif

endmodule

// File: tb/tb_row_track.sv
// tb_row_track: directed stimulus with a queued scoreboard for row_track.
// Timeout cases run only when ROW_TRACK_TIMEOUT_EN is defined.
module tb_row_track;

  localparam int ROWW  = 11;
  localparam int BANKB = 2;
  localparam int IMAX  = 4;

  logic        clk = 1'b0;
  logic        resl = 1'b0;
  logic [10:0] a = '0;
  logic [1:0]  bank = '0;
  logic        newrow = 1'b0;
  logic        access = 1'b0;
  logic        close = 1'b0;
  logic        closeall = 1'b0;
  logic        pack = 1'b0;
  logic        match;
  logic [3:0]  openmask;
  logic        preq;
  logic [1:0]  pbank;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic       m;
    logic [3:0] om;
    logic       pq;
    logic [1:0] pb;
    logic       ckpb;
  } exp_t;

  exp_t sbq[$];

  row_track #(
    .ROWW(ROWW),
    .BANKB(BANKB),
    .IDLE_MAX(IMAX)
  ) dut (
    .clk(clk),
    .resl(resl),
    .a(a),
    .bank(bank),
    .newrow(newrow),
    .access(access),
    .close(close),
    .closeall(closeall),
    .match(match),
    .openmask(openmask),
    .preq(preq),
    .pbank(pbank),
    .pack(pack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (match !== e.m || openmask !== e.om || preq !== e.pq ||
          (e.ckpb && pbank !== e.pb)) begin
        failures++;
        $display("FAIL %s: got m=%0b om=%b preq=%0b pbank=%0d want m=%0b om=%b preq=%0b pbank=%0d",
                 e.nm, match, openmask, preq, pbank, e.m, e.om, e.pq, e.pb);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_o(input string nm, input logic m, input logic [3:0] om,
                       input logic pq, input logic [1:0] pb, input logic ck = 1'b1);
    sbq.push_back('{nm, m, om, pq, pb, ck});
  endtask

  task automatic probe(input logic [1:0] b, input logic [10:0] ad);
    bank = b;
    a    = ad;
  endtask

  task automatic chk(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_preq(output int k);
    k = 0;
    while (!preq && k < 20) begin
      cyc();
      k++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : stim
    int k;
    #1;
    exp_o("reset", 1'b0, 4'b0000, 1'b0, 2'd0);
    #11;
    resl = 1'b1;
    newrow = 1'b1;
    probe(1, 11'h2A5);
    cyc();
    newrow = 1'b0;
    exp_o("hit_2a5", 1'b1, 4'b0010, 1'b0, 2'd0);
    cyc();
    probe(1, 11'h2A4);
    exp_o("miss_row", 1'b0, 4'b0010, 1'b0, 2'd0);
    cyc();
    probe(0, 11'h2A5);
    exp_o("miss_bank", 1'b0, 4'b0010, 1'b0, 2'd0);
    cyc();
    closeall = 1'b1;
    cyc();
    closeall = 1'b0;
    probe(1, 11'h2A5);
    exp_o("closed_keeps_row", 1'b0, 4'b0000, 1'b0, 2'd0);

    cyc();
    newrow = 1'b1;
    probe(0, 11'h011);
    cyc();
    probe(3, 11'h3C7);
    cyc();
    newrow = 1'b0;
    exp_o("open_b3", 1'b1, 4'b1001, 1'b0, 2'd0);
    cyc();
    probe(0, 11'h011);
    closeall = 1'b1;
    exp_o("open_b0", 1'b1, 4'b1001, 1'b0, 2'd0);
    cyc();
    closeall = 1'b0;
    exp_o("closeall_b0", 1'b0, 4'b0000, 1'b0, 2'd0);
    cyc();
    probe(3, 11'h3C7);
    exp_o("closeall_b3", 1'b0, 4'b0000, 1'b0, 2'd0);

    cyc();
    newrow = 1'b1;
    probe(2, 11'h055);
    cyc();
    newrow = 1'b0;
    close = 1'b1;
    exp_o("pre_close", 1'b1, 4'b0100, 1'b0, 2'd0);
    cyc();
    close = 1'b0;
    exp_o("close_b2", 1'b0, 4'b0000, 1'b0, 2'd0);
    cyc();
    newrow = 1'b1;
    close = 1'b1;
    probe(1, 11'h7FF);
    cyc();
    newrow = 1'b0;
    close = 1'b0;
    exp_o("newrow_over_close", 1'b1, 4'b0010, 1'b0, 2'd0);
    cyc();
    access = 1'b1;
    probe(1, 11'h7FE);
    exp_o("access_miss", 1'b0, 4'b0010, 1'b0, 2'd0);
    cyc();
    access = 1'b0;
    closeall = 1'b1;
    cyc();
    closeall = 1'b0;
    probe(1, 11'h7FF);
    exp_o("closeall2", 1'b0, 4'b0000, 1'b0, 2'd0);

    cyc();
    newrow = 1'b1;
    probe(3, 11'h3FF);
    cyc();
    newrow = 1'b0;
    exp_o("pre_reset", 1'b1, 4'b1000, 1'b0, 2'd0);
    cyc();
    #3;
    resl = 1'b0;
    #1;
    chk("async_rst_om", int'(openmask), 0, 0);
    chk("async_rst_match", int'(match), 0, 0);
    cyc();
    resl = 1'b1;

`ifndef ROW_TRACK_TIMEOUT_EN
    cyc();
    newrow = 1'b1;
    probe(2, 11'h123);
    cyc();
    newrow = 1'b0;
    pack = 1'b1;
    cyc(300);
    pack = 1'b0;
    exp_o("no_timeout", 1'b1, 4'b0100, 1'b0, 2'd0);
    cyc();
    closeall = 1'b1;
    cyc();
    closeall = 1'b0;
    exp_o("no_timeout_close", 1'b0, 4'b0000, 1'b0, 2'd0);
`else
    cyc();
    newrow = 1'b1;
    probe(2, 11'h123);
    cyc();
    newrow = 1'b0;
    wait_preq(k);
    chk("idle_latency", k, IMAX, IMAX + 3);
    exp_o("req_b2", 1'b1, 4'b0100, 1'b1, 2'd2);
    cyc(2);
    exp_o("req_hold", 1'b1, 4'b0100, 1'b1, 2'd2);
    pack = 1'b1;
    cyc();
    pack = 1'b0;
    exp_o("ack_b2", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    cyc(3);
    exp_o("ack_b2_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

    cyc();
    newrow = 1'b1;
    probe(1, 11'h0AA);
    cyc();
    newrow = 1'b0;
    for (int i = 0; i < 20; i++) begin
      access = (i % 3 == 2);
      exp_o("access_keeps", 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
      cyc();
    end
    access = 1'b0;
    closeall = 1'b1;
    cyc();
    closeall = 1'b0;

    newrow = 1'b1;
    probe(0, 11'h001);
    cyc();
    probe(3, 11'h003);
    cyc();
    probe(1, 11'h001);
    cyc();
    newrow = 1'b0;
    wait_preq(k);
    exp_o("arb_b0", 1'b1, 4'b1011, 1'b1, 2'd0);
    cyc(4);
    exp_o("arb_hold_b0", 1'b1, 4'b1011, 1'b1, 2'd0);
    pack = 1'b1;
    cyc();
    pack = 1'b0;
    exp_o("arb_ack0", 1'b1, 4'b1010, 1'b0, 2'd0, 1'b0);
    cyc();
    exp_o("arb_b1", 1'b1, 4'b1010, 1'b1, 2'd1);
    pack = 1'b1;
    cyc();
    pack = 1'b0;
    exp_o("arb_ack1", 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0);
    cyc();
    exp_o("arb_b3", 1'b0, 4'b1000, 1'b1, 2'd3);
    pack = 1'b1;
    cyc();
    pack = 1'b0;
    exp_o("arb_ack3", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

    cyc();
    newrow = 1'b1;
    probe(0, 11'h050);
    cyc();
    newrow = 1'b0;
    wait_preq(k);
    exp_o("b0_req", 1'b1, 4'b0001, 1'b1, 2'd0);
    cyc();
    newrow = 1'b1;
    pack = 1'b1;
    probe(0, 11'h100);
    cyc();
    newrow = 1'b0;
    pack = 1'b0;
    exp_o("newrow_with_ack", 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    cyc();
    wait_preq(k);
    chk("rereq_latency", k, IMAX - 1, IMAX + 3);
    #3;
    resl = 1'b0;
    #1;
    chk("async_rst_preq", int'(preq), 0, 0);
    chk("async_rst_pbank", int'(pbank), 0, 0);
    exp_o("rst_hold", 1'b0, 4'b0000, 1'b0, 2'd0);
    cyc();
    resl = 1'b1;
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
